// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register pending scoreboard for WAW/RAW tracking.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data (and clear rbusy) on read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NR     = 4,
  parameter int NW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NW-1:0]        we,
  input  logic [NW*ADDR_W-1:0] waddr,
  input  logic [NW*DATA_W-1:0] wdata,
  input  logic [NR*ADDR_W-1:0] raddr,
  output logic [NR*DATA_W-1:0] rdata,
  output logic [NR-1:0]        rbusy,
  input  logic                 alloc_valid,
  input  logic [ADDR_W-1:0]    alloc_addr,
  output logic                 alloc_ready,
  input  logic                 flush,
  output logic [ADDR_W:0]      busy_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              alloc_go;

  assign alloc_ready = ~busy[alloc_addr];
  assign alloc_go    = alloc_valid && alloc_ready && (alloc_addr != '0);

  // Priority: write clears, accepted alloc re-sets, flush overrides everything.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NW; k++) begin
      if (we[k]) busy_nxt[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (alloc_go) busy_nxt[alloc_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_nxt = count_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      // Later ports overwrite earlier ones on an address collision.
      for (int k = 0; k < NW; k++) begin
        if (we[k] && (waddr[k*ADDR_W +: ADDR_W] != '0))
          mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
      end
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  always_comb begin
    for (int j = 0; j < NR; j++) begin
      rdata[j*DATA_W +: DATA_W] = mem[raddr[j*ADDR_W +: ADDR_W]];
      rbusy[j]                  = busy[raddr[j*ADDR_W +: ADDR_W]];
`ifdef REGFILE_MP_BYPASS_EN
      // Forwarding is suppressed during reset so reads stay at zero.
      if (!rst && (raddr[j*ADDR_W +: ADDR_W] != '0)) begin
        for (int k = 0; k < NW; k++) begin
          if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == raddr[j*ADDR_W +: ADDR_W])) begin
            rdata[j*DATA_W +: DATA_W] = wdata[k*DATA_W +: DATA_W];
            rbusy[j]                  = 1'b0;
          end
        end
      end
`endif
    end
  end

endmodule
